// File: rtl/shot_launcher.sv
// Player fireball launcher: owns NUM_SHOTS slots, launches on fire, moves them right each frame.
// Optional build macro SHOT_AUTOFIRE_EN makes a held fire key re-arm the launch request every clk.
module shot_launcher #(
    parameter int NUM_SHOTS       = 3,
    parameter int X_SPEED         = 240,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int MUZZLE_DX       = 32,
    parameter int MUZZLE_DY       = 16,
    parameter int RIGHT_EDGE      = 640,
    parameter int PARK_X          = 1000
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             startOfFrame,
    input  logic                             pause,
    input  logic                             fire,
    input  logic signed [10:0]               playerTLX,
    input  logic signed [10:0]               playerTLY,
    input  logic [NUM_SHOTS-1:0]             shotDragonCollision,
    output logic [NUM_SHOTS-1:0]             shotActive,
    output logic [NUM_SHOTS-1:0][10:0]       shotTopLeftX,
    output logic [NUM_SHOTS-1:0][10:0]       shotTopLeftY,
    output logic                             launchPulse
);

    localparam int CW = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic signed [31:0] PARK_FX = 32'(PARK_X * 64);
    localparam logic signed [31:0] X_STEP  = 32'(X_SPEED);
    localparam logic signed [10:0] EDGE_X  = 11'(RIGHT_EDGE);

    logic signed [31:0]   pos_x [NUM_SHOTS];
    logic signed [31:0]   pos_y [NUM_SHOTS];
    logic [CW-1:0]        cooldown;
    logic                 firePending;
    logic                 fire_d;
    logic                 frame_go;
    logic                 launch;
    logic                 fire_set;
    logic                 found;
    logic [NUM_SHOTS-1:0] free;
    logic [NUM_SHOTS-1:0] launch_oh;
    logic [NUM_SHOTS-1:0] retire;
    logic signed [11:0]   launch_px;
    logic signed [11:0]   launch_py;
    logic signed [31:0]   launch_fx;
    logic signed [31:0]   launch_fy;

    // Pixel view is bits [16:6] of the x64 fixed point value: an arithmetic shift truncated to 11 bits.
    always_comb begin
        for (int i = 0; i < NUM_SHOTS; i++) begin
            shotTopLeftX[i] = pos_x[i][16:6];
            shotTopLeftY[i] = pos_y[i][16:6];
            retire[i]       = shotActive[i] && ($signed(shotTopLeftX[i]) >= EDGE_X);
        end
    end

    assign frame_go = startOfFrame && !pause;
    assign free     = ~shotActive & ~shotDragonCollision;

    always_comb begin
        launch_oh = '0;
        found     = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (free[i] && !found) begin
                launch_oh[i] = 1'b1;
                found        = 1'b1;
            end
        end
    end

    assign launch      = frame_go && firePending && (cooldown == '0) && (|free);
    assign launchPulse = launch && !reset;

`ifdef SHOT_AUTOFIRE_EN
    assign fire_set = fire;
`else
    assign fire_set = fire && !fire_d;
`endif

    assign launch_px = {playerTLX[10], playerTLX} + 12'(MUZZLE_DX);
    assign launch_py = {playerTLY[10], playerTLY} + 12'(MUZZLE_DY);
    assign launch_fx = {{14{launch_px[11]}}, launch_px, 6'b0};
    assign launch_fy = {{14{launch_py[11]}}, launch_py, 6'b0};

    always_ff @(posedge clk) begin
        if (reset) begin
            shotActive  <= '0;
            cooldown    <= '0;
            firePending <= 1'b0;
            fire_d      <= 1'b0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                pos_x[i] <= PARK_FX;
                pos_y[i] <= PARK_FX;
            end
        end else begin
            fire_d      <= fire;
            // A new edge arriving on the launch clk re-arms the request rather than being lost.
            firePending <= fire_set || (firePending && !launch);
            if (launch)
                cooldown <= CW'(COOLDOWN_FRAMES);
            else if (frame_go && cooldown != '0)
                cooldown <= cooldown - CW'(1);
            for (int i = 0; i < NUM_SHOTS; i++) begin
                if (shotActive[i] && shotDragonCollision[i]) begin
                    shotActive[i] <= 1'b0;
                    pos_x[i]      <= PARK_FX;
                    pos_y[i]      <= PARK_FX;
                end else if (frame_go && shotActive[i]) begin
                    if (retire[i]) begin
                        shotActive[i] <= 1'b0;
                        pos_x[i]      <= PARK_FX;
                        pos_y[i]      <= PARK_FX;
                    end else begin
                        pos_x[i] <= pos_x[i] + X_STEP;
                    end
                end else if (launch && launch_oh[i]) begin
                    shotActive[i] <= 1'b1;
                    pos_x[i]      <= launch_fx;
                    pos_y[i]      <= launch_fy;
                end
            end
        end
    end

endmodule

// File: tb/tb_shot_launcher.sv
// Scoreboard bench for shot_launcher: expected launches are queued at fire time and matched on launchPulse.
module tb_shot_launcher;
    localparam int N = 3;

    logic               clk = 1'b0;
    logic               reset, startOfFrame, pause, fire;
    logic signed [10:0] playerTLX, playerTLY;
    logic [N-1:0]       shotDragonCollision, shotActive;
    logic [N-1:0][10:0] shotTopLeftX, shotTopLeftY;
    logic               launchPulse;

    int errors = 0;
    int checks = 0;
    int fr     = 0;

    typedef struct {int frame; int slot; int x; int y;} exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    shot_launcher dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (startOfFrame),
        .pause              (pause),
        .fire               (fire),
        .playerTLX          (playerTLX),
        .playerTLY          (playerTLY),
        .shotDragonCollision(shotDragonCollision),
        .shotActive         (shotActive),
        .shotTopLeftX       (shotTopLeftX),
        .shotTopLeftY       (shotTopLeftY),
        .launchPulse        (launchPulse)
    );

    // Pixel X of a shot launched at 132 after m frame moves of 240/64 px.
    function automatic int expx(input int m);
        return (132 * 64 + m * 240) >>> 6;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; fire = 1'b0; pause = 1'b0; startOfFrame = 1'b0;
        shotDragonCollision = '0; playerTLX = 11'sd100; playerTLY = 11'sd200;
        tick(); tick();
        reset = 1'b0;
        q.delete();
        fr = 0;
    endtask

    task automatic fire_pulse();
        fire = 1'b1; tick();
        fire = 1'b0; tick();
    endtask

    task automatic push(input int f, input int s);
        exp_t e;
        e.frame = f; e.slot = s; e.x = 132; e.y = 216;
        q.push_back(e);
    endtask

    // One startOfFrame clk; any launchPulse is matched against the head of the queue.
    task automatic do_frame();
        exp_t e;
        logic lp;
        bit due;
        startOfFrame = 1'b1;
        #3;
        lp = launchPulse;
        due = (q.size() != 0) && (q[0].frame == fr);
        tick();
        startOfFrame = 1'b0;
        if (lp || due) begin
            checks++;
            if (!lp) begin
                errors++;
                $display("FAIL missing_launch frame=%0d got launchPulse=0 want 1 (slot %0d)", fr, q[0].slot);
                void'(q.pop_front());
            end else if (!due) begin
                errors++;
                $display("FAIL unexpected_launch frame=%0d got launchPulse=1 want 0", fr);
            end else begin
                e = q.pop_front();
                checks += 3;
                if (shotActive[e.slot] !== 1'b1) begin
                    errors++; $display("FAIL launch_slot frame=%0d got shotActive=%b want slot %0d set", fr, shotActive, e.slot);
                end
                if (shotTopLeftX[e.slot] !== 11'(e.x)) begin
                    errors++; $display("FAIL launch_x frame=%0d got %0d want %0d", fr, shotTopLeftX[e.slot], e.x);
                end
                if (shotTopLeftY[e.slot] !== 11'(e.y)) begin
                    errors++; $display("FAIL launch_y frame=%0d got %0d want %0d", fr, shotTopLeftY[e.slot], e.y);
                end
            end
        end
        fr++;
        tick();
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL %s_pending got %0d launches outstanding want 0", name, q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks += 2;
        if (shotActive !== 3'b000) begin errors++; $display("FAIL reset_active got %b want 000", shotActive); end
        if (launchPulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", launchPulse); end
        for (int i = 0; i < N; i++) begin
            checks += 2;
            if (shotTopLeftX[i] !== 11'd1000) begin errors++; $display("FAIL reset_x%0d got %0d want 1000", i, shotTopLeftX[i]); end
            if (shotTopLeftY[i] !== 11'd1000) begin errors++; $display("FAIL reset_y%0d got %0d want 1000", i, shotTopLeftY[i]); end
        end
    endtask

    task automatic test_single();
        do_reset();
        fire_pulse(); push(0, 0);
        do_frame(); do_frame(); do_frame();
        checks += 2;
        if (shotTopLeftX[0] !== 11'(expx(2))) begin errors++; $display("FAIL single_move_x got %0d want %0d", shotTopLeftX[0], expx(2)); end
        if (shotTopLeftY[0] !== 11'd216) begin errors++; $display("FAIL single_move_y got %0d want 216", shotTopLeftY[0]); end
        check_drained("single");
    endtask

    task automatic test_four();
        int k = 0;
        while (expx(k) < 640) k++;
        do_reset();
        for (int f = 0; f <= k + 2; f++) begin
            if (f == 0 || f == 10 || f == 20 || f == 30) begin
                fire_pulse();
                push((f == 30) ? k + 2 : f, (f == 30) ? 0 : f / 10);
            end
            do_frame();
            if (f == k + 1) begin
                checks += 2;
                if (shotActive !== 3'b110) begin errors++; $display("FAIL retire_active got %b want 110", shotActive); end
                if (shotTopLeftX[0] !== 11'd1000) begin errors++; $display("FAIL retire_park got %0d want 1000", shotTopLeftX[0]); end
            end
        end
        check_drained("four");
    endtask

    task automatic test_cooldown();
        do_reset();
        fire_pulse(); push(0, 0);
        do_frame();
        fire_pulse(); push(9, 1);
        for (int f = 1; f < 12; f++) do_frame();
        check_drained("cooldown");
    endtask

    task automatic test_collision();
        do_reset();
        for (int f = 0; f < 20; f++) begin
            if (f == 0 || f == 9 || f == 18) begin fire_pulse(); push(f, f / 9); end
            do_frame();
        end
        shotDragonCollision = 3'b010;
        do_frame();
        shotDragonCollision = 3'b000;
        checks += 5;
        if (shotActive !== 3'b101) begin errors++; $display("FAIL hit_active got %b want 101", shotActive); end
        if (shotTopLeftX[1] !== 11'd1000 || shotTopLeftY[1] !== 11'd1000) begin
            errors++; $display("FAIL hit_park got %0d/%0d want 1000/1000", shotTopLeftX[1], shotTopLeftY[1]);
        end
        if (shotTopLeftX[0] !== 11'(expx(20))) begin errors++; $display("FAIL hit_x0 got %0d want %0d", shotTopLeftX[0], expx(20)); end
        if (shotTopLeftX[2] !== 11'(expx(2))) begin errors++; $display("FAIL hit_x2 got %0d want %0d", shotTopLeftX[2], expx(2)); end
        if (shotTopLeftY[0] !== 11'd216) begin errors++; $display("FAIL hit_y0 got %0d want 216", shotTopLeftY[0]); end
        check_drained("collision");
    endtask

    task automatic test_pause();
        do_reset();
        for (int f = 0; f < 18; f++) begin
            if (f == 0 || f == 9) begin fire_pulse(); push(f, f / 9); end
            do_frame();
        end
        fire_pulse();
        pause = 1'b1;
        for (int f = 0; f < 5; f++) do_frame();
        pause = 1'b0;
        checks += 3;
        if (shotActive !== 3'b011) begin errors++; $display("FAIL pause_active got %b want 011", shotActive); end
        if (shotTopLeftX[0] !== 11'(expx(17))) begin errors++; $display("FAIL pause_x0 got %0d want %0d", shotTopLeftX[0], expx(17)); end
        if (shotTopLeftX[1] !== 11'(expx(8))) begin errors++; $display("FAIL pause_x1 got %0d want %0d", shotTopLeftX[1], expx(8)); end
        push(fr, 2);
        do_frame();
        check_drained("pause");
    endtask

    task automatic test_held();
        do_reset();
`ifdef SHOT_AUTOFIRE_EN
        push(0, 0); push(9, 1); push(18, 2);
`else
        push(0, 0);
`endif
        fire = 1'b1;
        tick();
        for (int f = 0; f < 40; f++) do_frame();
        fire = 1'b0;
        checks++;
`ifdef SHOT_AUTOFIRE_EN
        if (shotActive !== 3'b111) begin errors++; $display("FAIL held_active got %b want 111", shotActive); end
`else
        if (shotActive !== 3'b001) begin errors++; $display("FAIL held_active got %b want 001", shotActive); end
`endif
        check_drained("held");
    endtask

    task automatic test_midflight_reset();
        do_reset();
        fire_pulse(); push(0, 0);
        do_frame(); do_frame();
        fire_pulse();
        reset = 1'b1; tick(); reset = 1'b0;
        fr = 0;
        checks += 2;
        if (shotActive !== 3'b000) begin errors++; $display("FAIL midreset_active got %b want 000", shotActive); end
        if (shotTopLeftX[0] !== 11'd1000) begin errors++; $display("FAIL midreset_park got %0d want 1000", shotTopLeftX[0]); end
        do_frame();
        fire_pulse(); push(1, 0);
        do_frame();
        check_drained("midreset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_four();
        test_cooldown();
        test_collision();
        test_pause();
        test_held();
        test_midflight_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shot_launcher.md
Name: shot_launcher

Overview:
- Player-side producer of the shot/dragon collision interface: owns up to NUM_SHOTS fireballs, launches them from the player position on a fire request, and moves them rightward once per frame.
- Drives per-slot shot positions to the shot drawers.
- Retires a slot when its bit in shotDragonCollision is set, or when the shot leaves the right edge.
- Bit i of shotDragonCollision always refers to slot i of this block.

Parameters:
- NUM_SHOTS, 3, number of shot slots; equals width of shotDragonCollision.
- X_SPEED, 240, shot X step per frame in fixed point (x64); positive means rightward.
- COOLDOWN_FRAMES, 8, minimum frames between two launches.
- MUZZLE_DX, 32, pixel X offset from playerTLX to the launch point.
- MUZZLE_DY, 16, pixel Y offset from playerTLY to the launch point.
- RIGHT_EDGE, 640, pixel X at or beyond which a shot retires.
- PARK_X, 1000, pixel X/Y used for inactive slots (off-screen).

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- startOfFrame, in, 1, one-clk pulse per frame.
- pause, in, 1, freezes motion, cooldown and launch.
- fire, in, 1, fire key level.
- playerTLX, in, 11 signed, player top-left X in pixels.
- playerTLY, in, 11 signed, player top-left Y in pixels.
- shotDragonCollision, in, NUM_SHOTS, per-slot hit from the collision block.
- shotActive, out, NUM_SHOTS, slot i in flight.
- shotTopLeftX, out, NUM_SHOTS x 11 signed, per-slot pixel X.
- shotTopLeftY, out, NUM_SHOTS x 11 signed, per-slot pixel Y.
- launchPulse, out, 1, one clk high on the startOfFrame cycle a launch occurs.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, sampled on posedge clk. No other reset exists.
- Reset state:
  - all shotActive = 0;
  - all fixed-point X/Y = PARK_X*64, so outputs read PARK_X;
  - cooldown = 0, firePending = 0, fire_d = 0, launchPulse = 0.
- Position arithmetic:
  - Per-slot positions are 32-bit signed fixed point, multiplier 64.
  - Outputs = fixed >>> 6 (arithmetic shift), truncated to 11 bits.
- Fire request capture, every clk:
  - fire_d <= fire.
  - A rising edge (fire & !fire_d) sets firePending.
  - firePending holds until a launch consumes it or reset clears it; it is not cleared by pause.
- Collision, every clk, before frame logic:
  - A slot with its shotDragonCollision bit set gets shotActive <= 0 and position <= PARK_X*64.
  - A collision bit on an inactive slot has no effect.
- Frame update, on startOfFrame with pause = 0:
  - Move: each active slot not colliding this clk gets X <= X + X_SPEED; Y is unchanged.
  - Retire: an active slot whose current shotTopLeftX >= RIGHT_EDGE gets shotActive <= 0 and is parked. This check uses the pre-move value, so retirement takes effect one frame after crossing.
  - Cooldown: if cooldown != 0, cooldown <= cooldown - 1.
  - Launch condition: firePending = 1, cooldown = 0, and at least one slot is inactive at the start of this clk and not colliding.
  - Launch action:
    - the lowest-index such slot gets shotActive <= 1, X <= (playerTLX + MUZZLE_DX)*64, Y <= (playerTLY + MUZZLE_DY)*64;
    - cooldown <= COOLDOWN_FRAMES;
    - firePending <= 0;
    - launchPulse = 1 for this clk.
  - A slot retired this frame is not reusable until the next frame. The launched slot does not move in its launch frame.
  - At most one launch per frame.
- When no slot is free: firePending stays set and launches at the first eligible frame.
- startOfFrame with pause = 1: no move, no retire, no cooldown change, no launch. Collisions still apply.
- Simultaneous collision and startOfFrame on one slot: collision wins. The slot parks, does not move, and cannot be relaunched in that clk.
- Reset asserted mid-flight: all slots are parked and inactive on the next edge, and pending fire is dropped.

Optional Feature:
- Macro SHOT_AUTOFIRE_EN.
- Defined: firePending is additionally set on every clk while fire = 1 (level-triggered). A held key then launches every COOLDOWN_FRAMES+1 frames while a slot is free.
- Undefined: only rising edges of fire set firePending, so a held key fires exactly once.

Test Plan:
- Reset, then fire pulse with playerTLX=100, playerTLY=200 -> next startOfFrame: launchPulse=1, shotActive=001, slot0 X=132, Y=216. After 2 more frames slot0 X=132+2*240/64=139 (fixed-point exact 139.5 -> 139).
- Four fire edges, each 10 frames apart, shots not hit -> slots 0,1,2 launch in order; the 4th stays pending until the first slot retires past X>=640, then that slot index relaunches.
- Fire edges on consecutive frames -> second launch occurs exactly COOLDOWN_FRAMES+1=9 frames after the first.
- shotDragonCollision=010 asserted on the same clk as startOfFrame with slot1 active -> slot1 inactive, outputs 1000/1000, no move; slot0 and slot2 move normally.
- pause=1 for 5 frames with 2 active shots and a pending fire -> positions and cooldown unchanged, no launch; pause=0 -> launch on the next frame.
- SHOT_AUTOFIRE_EN defined, fire held 40 frames, no hits -> launches at frames 1, 10, 19, then none while all 3 slots are active.
